fetch_ctl: RTL and testbench
============================

# fetch_ctl

Sequencer for the pipelined processor's fetch stage. Drives the PC-source and exception-vector selects and the PC update enable, handles a variable-latency instruction memory, and holds branch, ERET and exception redirects that arrive while a fetch is outstanding. Also owns the exception link state (ELR, ESR, in-handler flag) and detects double faults.

## Interface
Parameters:
- N, 64, address/data width
- CODE_W, 4, exception code width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- imem_ready  in  1  instruction memory returns the word for the current PC this cycle
- stall_D  in  1  decode hazard stall; PC must hold
- branch_E  in  1  taken branch resolved in execute
- branch_target_E  in  N  target of branch_E
- exc_req  in  1  exception raised by execute
- exc_pc  in  N  PC of the faulting instruction
- exc_code  in  CODE_W  cause
- eret  in  1  ERET resolved in execute
- imem_req  out  1  fetch request
- pc_en  out  1  PC register update enable
- PCSrc_F  out  1  select redirect target in the fetch mux
- PCBranch_F  out  N  redirect target (branch target or ELR)
- EProc_F  out  1  select exception vector
- flush_D  out  1  kill the IF/ID instruction
- flush_E  out  1  kill the ID/EX instruction
- elr  out  N  saved exception PC
- esr  out  CODE_W  saved cause
- exc_active  out  1  executing the handler
- halted  out  1  double fault; fetch stopped

## Operation
- States: IDLE, RUN, HALT.
- IDLE: entered at reset. All outputs are 0. Moves to RUN on the first clock after reset deasserts.
- RUN:
  - imem_req=1.
  - pc_en = imem_ready & ~stall_D.
  - A fetch completes on a cycle with pc_en=1.
- Redirects are registered as pending. Pending bits: pend_br (with br_tgt_q) and pend_exc.
  - A redirect arriving on a completing cycle is applied in that same cycle.
  - A redirect arriving on a non-completing cycle is held until the next completing cycle.
  - On the applying cycle the pending bit clears.
- Redirect priority when requests coincide or overlap: exc_req > eret > branch_E.
  - exc_req clears any pending branch.
  - A new branch_E replaces the pending target.
- exc_req with exc_active=0:
  - elr<=exc_pc, esr<=exc_code, exc_active<=1.
  - EProc_F=1 on the applying cycle; PCSrc_F=0.
- exc_req with exc_active=1: double fault.
  - Go to HALT; halted=1.
- eret:
  - Treated as a branch with target elr.
  - Clears exc_active when applied.
  - eret with exc_active=0 is ignored; no redirect.
- PCBranch_F = pend_br ? br_tgt_q : (eret ? elr : branch_target_E).
- PCSrc_F=1 only on an applying cycle of a branch or eret redirect.
- flush_D=1 and flush_E=1:
  - combinationally in the cycle a redirect request is accepted;
  - and on its applying cycle.
- HALT: imem_req, pc_en, PCSrc_F and EProc_F are 0. Left only by reset.
- A stalled cycle (stall_D=1) never applies a redirect. The redirect stays pending.

## Timing
- Reset (asynchronous, active-low):
  - State returns to IDLE.
  - pend_br, pend_exc, br_tgt_q, elr, esr, exc_active and halted clear to 0.
  - All outputs are forced to 0 while reset is asserted, including flush_D, flush_E and PCBranch_F.
  - Reset mid-wait drops any pending redirect.
- Select and enable outputs are Mealy: combinational from state, pending registers and same-cycle inputs.
- Latency from request to PC change:
  - 0 cycles if imem_ready=1 and stall_D=0 in the request cycle.
  - Otherwise k cycles, where k is the number of cycles until the next completing cycle.
- elr, esr and exc_active update on the clock edge that accepts the request. They are visible the next cycle.

## Structure
- A shared package holds:
  - the state enum: IDLE, RUN, HALT;
  - CODE_W;
  - the cause constants: EXC_NONE=0, EXC_UNDEF=1, EXC_MISALIGN=2, EXC_SVC=3.
- One natural sub-module: redirect_hold. It is the pending-redirect register with priority merge and outputs pend_br, br_tgt_q and pend_exc.
- FSM and exception registers live at the top level.

## Test plan
- Reset then imem_ready=1 and stall_D=0 constantly:
  - cycle 1 is IDLE with imem_req=0;
  - from cycle 2, imem_req=1 and pc_en=1 every cycle;
  - PCSrc_F=0 and EProc_F=0 throughout.
- branch_E=1 with target 0x40 while imem_ready=0 for 3 cycles:
  - flush_D/flush_E pulse in the request cycle;
  - when ready rises, pc_en=1, PCSrc_F=1 and PCBranch_F=0x40 in that cycle only.
- exc_req with exc_pc=0x1C and code=1, coincident with branch_E:
  - exception wins; EProc_F=1 and PCSrc_F=0;
  - next cycle elr=0x1C, esr=1, exc_active=1;
  - the branch never applies.
- eret inside the handler (elr=0x1C):
  - PCSrc_F=1 with PCBranch_F=0x1C;
  - exc_active=0 the cycle after;
  - a later eret while exc_active=0 causes no redirect.
- Second exc_req while exc_active=1:
  - halted=1 and imem_req=0 from the next cycle, held until reset.
- reset asserted during a pending branch (imem_ready=0):
  - all outputs go to 0 immediately;
  - after deassert there is no redirect, and fetch restarts via IDLE.

Source files
------------

// File: rtl/fetch_ctl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
//   fetch_state_e : sequencer states (IDLE, RUN, HALT)
//   CODE_W        : default exception cause width
//   EXC_*         : exception cause encodings
package fetch_ctl_pkg;

  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [CODE_W-1:0] EXC_NONE     = CODE_W'(0);
  localparam logic [CODE_W-1:0] EXC_UNDEF    = CODE_W'(1);
  localparam logic [CODE_W-1:0] EXC_MISALIGN = CODE_W'(2);
  localparam logic [CODE_W-1:0] EXC_SVC      = CODE_W'(3);

endpackage

// File: rtl/fetch_ctl_redirect_hold.sv
// Pending-redirect register with priority merge (exception > eret > branch).
// Requests arrive already qualified by the sequencer; a completing fetch or a
// clear drops everything held, since the redirect is applied that cycle.
//   i_clr      : drop pending state (double fault)
//   i_complete : fetch completes this cycle, pending redirect is applied
//   i_exc      : accepted exception request
//   i_eret     : accepted ERET (target i_elr)
//   i_br       : accepted taken branch (target i_br_tgt)
//   o_pend_br  : branch/ERET redirect waiting, target in o_br_tgt_q
//   o_pend_exc : exception redirect waiting
module fetch_ctl_redirect_hold #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_complete,
  input  logic         i_exc,
  input  logic         i_eret,
  input  logic         i_br,
  input  logic [N-1:0] i_elr,
  input  logic [N-1:0] i_br_tgt,
  output logic         o_pend_br,
  output logic         o_pend_exc,
  output logic [N-1:0] o_br_tgt_q
);

  logic         r_pend_br;
  logic         r_pend_exc;
  logic [N-1:0] r_br_tgt_q;

  // An exception wipes a held branch; a newer branch/ERET replaces the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_br  <= 1'b0;
      r_pend_exc <= 1'b0;
      r_br_tgt_q <= '0;
    end else if (i_clr || i_complete) begin
      r_pend_br  <= 1'b0;
      r_pend_exc <= 1'b0;
    end else if (i_exc) begin
      r_pend_exc <= 1'b1;
      r_pend_br  <= 1'b0;
    end else if (i_eret) begin
      r_pend_br  <= 1'b1;
      r_br_tgt_q <= i_elr;
    end else if (i_br) begin
      r_pend_br  <= 1'b1;
      r_br_tgt_q <= i_br_tgt;
    end
  end

  assign o_pend_br  = r_pend_br;
  assign o_pend_exc = r_pend_exc;
  assign o_br_tgt_q = r_br_tgt_q;

endmodule

// File: rtl/fetch_ctl.sv
// Fetch-stage sequencer: PC-source/exception-vector selects, PC update enable,
// redirect holding across a variable-latency instruction memory, exception
// link state (elr/esr/exc_active) and double-fault halt.
//   clk, reset (async active-low)
//   imem_ready, stall_D                     : fetch completion inputs
//   branch_E/branch_target_E, eret          : execute-stage redirects
//   exc_req/exc_pc/exc_code                 : execute-stage exception
//   imem_req, pc_en, PCSrc_F, PCBranch_F,
//   EProc_F, flush_D, flush_E               : Mealy selects/enables
//   elr, esr, exc_active, halted            : exception link state
module fetch_ctl #(
  parameter int unsigned N      = 64,
  parameter int unsigned CODE_W = fetch_ctl_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_ready,
  input  logic              stall_D,
  input  logic              branch_E,
  input  logic [N-1:0]      branch_target_E,
  input  logic              exc_req,
  input  logic [N-1:0]      exc_pc,
  input  logic [CODE_W-1:0] exc_code,
  input  logic              eret,
  output logic              imem_req,
  output logic              pc_en,
  output logic              PCSrc_F,
  output logic [N-1:0]      PCBranch_F,
  output logic              EProc_F,
  output logic              flush_D,
  output logic              flush_E,
  output logic [N-1:0]      elr,
  output logic [CODE_W-1:0] esr,
  output logic              exc_active,
  output logic              halted
);

  import fetch_ctl_pkg::*;

  fetch_state_e r_state, w_state_d;

  logic              r_exc_active;
  logic              r_halted;
  logic [N-1:0]      r_elr;
  logic [CODE_W-1:0] r_esr;

  logic         w_run, w_complete, w_dbl;
  logic         w_exc_ok, w_eret_ok, w_br_ok, w_accept;
  logic         w_apply_exc, w_apply_br;
  logic         w_pend_br, w_pend_exc;
  logic [N-1:0] w_br_tgt_q;

  // Request qualification: exception > eret > branch. A held exception blocks
  // later branch/ERET requests; an ERET outside the handler is ignored.
  assign w_run       = (r_state == RUN);
  assign w_complete  = w_run & imem_ready & ~stall_D;
  assign w_dbl       = w_run & exc_req & r_exc_active;
  assign w_exc_ok    = w_run & exc_req & ~r_exc_active;
  assign w_eret_ok   = w_run & eret & r_exc_active & ~exc_req & ~w_pend_exc;
  assign w_br_ok     = w_run & branch_E & ~exc_req & ~w_eret_ok & ~w_pend_exc;
  assign w_accept    = w_exc_ok | w_eret_ok | w_br_ok;
  assign w_apply_exc = w_complete & (w_pend_exc | w_exc_ok);
  assign w_apply_br  = w_complete & ~w_apply_exc & (w_pend_br | w_eret_ok | w_br_ok);

  fetch_ctl_redirect_hold #(.N(N)) u_redirect_hold (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (w_dbl),
    .i_complete (w_complete),
    .i_exc      (w_exc_ok),
    .i_eret     (w_eret_ok),
    .i_br       (w_br_ok),
    .i_elr      (r_elr),
    .i_br_tgt   (branch_target_E),
    .o_pend_br  (w_pend_br),
    .o_pend_exc (w_pend_exc),
    .o_br_tgt_q (w_br_tgt_q)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_d;
  end

  // Next state and Mealy outputs; everything is zero outside RUN
  always_comb begin
    w_state_d  = r_state;
    imem_req   = 1'b0;
    pc_en      = 1'b0;
    PCSrc_F    = 1'b0;
    EProc_F    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    PCBranch_F = '0;
    unique case (r_state)
      IDLE: w_state_d = RUN;
      RUN: begin
        imem_req   = 1'b1;
        pc_en      = w_complete;
        PCSrc_F    = w_apply_br;
        EProc_F    = w_apply_exc;
        flush_D    = w_accept | w_apply_br | w_apply_exc;
        flush_E    = w_accept | w_apply_br | w_apply_exc;
        PCBranch_F = w_pend_br ? w_br_tgt_q : ((eret & r_exc_active) ? r_elr : branch_target_E);
        if (w_dbl) w_state_d = HALT;
      end
      HALT: w_state_d = HALT;
      default: w_state_d = IDLE;
    endcase
  end

  // Exception link state updates on the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_elr        <= '0;
      r_esr        <= EXC_NONE;
      r_exc_active <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      if (w_exc_ok) begin
        r_elr        <= exc_pc;
        r_esr        <= exc_code;
        r_exc_active <= 1'b1;
      end else if (w_eret_ok) begin
        r_exc_active <= 1'b0;
      end
      if (w_dbl) r_halted <= 1'b1;
    end
  end

  assign elr        = r_elr;
  assign esr        = r_esr;
  assign exc_active = r_exc_active;
  assign halted     = r_halted;

endmodule

// File: tb/tb_fetch_ctl.sv
// Self-checking bench for fetch_ctl: directed scenarios plus randomized traffic,
// every cycle compared against a redirect-kind reference model.
module tb_fetch_ctl;

  localparam int unsigned N      = 64;
  localparam int unsigned CODE_W = 4;

  localparam int K_NONE = 0;
  localparam int K_BR   = 1;
  localparam int K_ERET = 2;
  localparam int K_EXC  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_ready, stall_D, branch_E, exc_req, eret;
  logic [N-1:0]      branch_target_E, exc_pc;
  logic [CODE_W-1:0] exc_code;
  logic              imem_req, pc_en, PCSrc_F, EProc_F, flush_D, flush_E;
  logic [N-1:0]      PCBranch_F, elr;
  logic [CODE_W-1:0] esr;
  logic              exc_active, halted;

  fetch_ctl #(.N(N), .CODE_W(CODE_W)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .stall_D(stall_D),
    .branch_E(branch_E), .branch_target_E(branch_target_E), .exc_req(exc_req),
    .exc_pc(exc_pc), .exc_code(exc_code), .eret(eret), .imem_req(imem_req),
    .pc_en(pc_en), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F), .EProc_F(EProc_F),
    .flush_D(flush_D), .flush_E(flush_E), .elr(elr), .esr(esr),
    .exc_active(exc_active), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: running/halted flags, link state, one held redirect
  bit          m_run, m_halt, m_active;
  logic [63:0] m_elr, m_ptgt;
  logic [3:0]  m_esr;
  int          m_pk;

  // Snapshots of the last stepped cycle for directed checks
  logic        s_req, s_pcsrc, s_eproc, s_flush, s_halted;
  logic [63:0] s_pcb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_active = 0;
    m_elr = '0; m_esr = '0; m_pk = K_NONE; m_ptgt = '0;
  endtask

  // One clock: drive at negedge, compare before the posedge, advance model
  task automatic step(input bit rdy, input bit stl, input bit br, input logic [63:0] bt,
                      input bit ex, input logic [63:0] epc, input logic [3:0] ec, input bit er);
    int nk, ak;
    bit live, comp, dbl;
    @(negedge clk);
    imem_ready = rdy; stall_D = stl; branch_E = br; branch_target_E = bt;
    exc_req = ex; exc_pc = epc; exc_code = ec; eret = er;
    #2;
    live = m_run && !m_halt;
    comp = live && rdy && !stl;
    dbl  = live && ex && m_active;
    nk = K_NONE;
    if (live) begin
      if (ex && !m_active)                      nk = K_EXC;
      else if (!ex && m_pk != K_EXC && er && m_active) nk = K_ERET;
      else if (!ex && m_pk != K_EXC && br)      nk = K_BR;
    end
    ak = K_NONE;
    if (comp) ak = (nk == K_EXC) ? K_EXC : ((m_pk != K_NONE) ? m_pk : nk);

    chk("imem_req", imem_req, 64'(live));
    chk("pc_en", pc_en, 64'(comp));
    chk("PCSrc_F", PCSrc_F, 64'(ak == K_BR || ak == K_ERET));
    chk("EProc_F", EProc_F, 64'(ak == K_EXC));
    if (!m_halt) begin
      chk("flush_D", flush_D, 64'(live && (nk != K_NONE || ak != K_NONE)));
      chk("flush_E", flush_E, 64'(live && (nk != K_NONE || ak != K_NONE)));
    end
    if (ak == K_BR || ak == K_ERET)
      chk("PCBranch_F", PCBranch_F, (m_pk == K_BR) ? m_ptgt : ((nk == K_ERET) ? m_elr : bt));
    else if (!m_run)
      chk("PCBranch_F_idle", PCBranch_F, 64'd0);
    chk("elr", elr, m_elr);
    chk("esr", 64'(esr), 64'(m_esr));
    chk("exc_active", exc_active, 64'(m_active));
    chk("halted", halted, 64'(m_halt));

    s_req = imem_req; s_pcsrc = PCSrc_F; s_eproc = EProc_F;
    s_flush = flush_D; s_halted = halted; s_pcb = PCBranch_F;

    if (comp || dbl) m_pk = K_NONE;
    else if (nk != K_NONE) begin
      m_pk   = (nk == K_EXC) ? K_EXC : K_BR;
      m_ptgt = (nk == K_ERET) ? m_elr : bt;
    end
    if (nk == K_EXC) begin m_elr = epc; m_esr = ec; m_active = 1; end
    if (nk == K_ERET) m_active = 0;
    if (dbl) m_halt = 1;
    m_run = 1;
    @(posedge clk);
  endtask

  // Assert reset mid-cycle with live requests on the inputs; outputs must drop at once
  task automatic do_reset();
    @(posedge clk); #3;
    imem_ready = 1; branch_E = 1; exc_req = 1; eret = 1; branch_target_E = 64'h55;
    reset = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 64'd0);
    chk("rst_pc_en", pc_en, 64'd0);
    chk("rst_PCSrc_F", PCSrc_F, 64'd0);
    chk("rst_EProc_F", EProc_F, 64'd0);
    chk("rst_flush_D", flush_D, 64'd0);
    chk("rst_flush_E", flush_E, 64'd0);
    chk("rst_PCBranch_F", PCBranch_F, 64'd0);
    chk("rst_elr", elr, 64'd0);
    chk("rst_exc_active", exc_active, 64'd0);
    chk("rst_halted", halted, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    imem_ready = 0; branch_E = 0; exc_req = 0; eret = 0; branch_target_E = '0;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    bit rdy, stl, br, ex, er, free;
    logic [63:0] bt, epc;
    reset = 1'b0; imem_ready = 0; stall_D = 0; branch_E = 0; exc_req = 0; eret = 0;
    branch_target_E = '0; exc_pc = '0; exc_code = '0;
    model_reset();

    // Straight-line fetch after reset
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_req", s_req, 64'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("run_req", s_req, 64'd1);

    // Branch held across three not-ready cycles
    step(0, 0, 1, 64'h40, 0, 0, 0, 0);
    chk("br_req_flush", s_flush, 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_apply_src", s_pcsrc, 64'd1);
    chk("br_apply_tgt", s_pcb, 64'h40);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_once", s_pcsrc, 64'd0);

    // Exception coincident with a branch
    step(1, 0, 1, 64'h80, 1, 64'h1C, 4'd1, 0);
    chk("exc_eproc", s_eproc, 64'd1);
    chk("exc_pcsrc", s_pcsrc, 64'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("exc_no_branch", s_pcsrc, 64'd0);

    // ERET back to elr, then a stray ERET outside the handler
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("eret_src", s_pcsrc, 64'd1);
    chk("eret_tgt", s_pcb, 64'h1C);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("eret_ignored_src", s_pcsrc, 64'd0);
    chk("eret_ignored_flush", s_flush, 64'd0);

    // Randomized traffic with stalls and not-ready cycles
    for (int i = 0; i < 400; i++) begin
      rdy  = ($urandom_range(0, 9) < 6);
      stl  = ($urandom_range(0, 9) < 2);
      free = (m_pk == K_NONE);
      ex   = !m_active && ($urandom_range(0, 19) == 0);
      er   = free && ($urandom_range(0, 5) == 0);
      br   = free && ($urandom_range(0, 7) == 0);
      bt   = {$urandom(), $urandom()};
      epc  = {$urandom(), $urandom()};
      step(rdy, stl, br, bt, ex, epc, 4'($urandom_range(0, 3)), er);
    end

    // Double fault halts fetch until reset
    if (!m_active) step(1, 0, 0, 0, 1, 64'h200, 4'd2, 0);
    step(1, 0, 0, 0, 1, 64'h300, 4'd3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("dbl_halted", s_halted, 64'd1);
    chk("dbl_req", s_req, 64'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 64'h10, 0, 0, 0, 1);

    // Reset while a branch is held
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 64'h99, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_restart_idle", s_req, 64'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_no_redirect", s_pcsrc, 64'd0);
    chk("rst_restart_run", s_req, 64'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
